dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Handshaked data-memory responder. It serves load/store requests from a multicycle or pipelined CPU datapath through a valid/ready request channel and a valid/ready response channel. Each access takes a fixed LATENCY, which models a slow data memory. The block replaces the combinational data memory when the core is the initiator. It holds a word-addressed RAM and allows one transaction outstanding at a time.

Parameters:
ADDR_WIDTH, 8, word-address bits; the array holds 2**ADDR_WIDTH 32-bit words.
LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  initiator presents a request
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
resp_valid  output  1  response available
resp_ready  input  1  initiator accepts the response
resp_rdata  output  32  load data; 0 for stores
resp_err  output  1  access error flag, valid with resp_valid
busy  output  1  a transaction is in flight (any state other than IDLE)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state = IDLE; req_ready = 1 after reset deasserts; resp_valid = 0; resp_rdata = 0; resp_err = 0; busy = 0; latency counter = 0. All RAM words clear to 0 in the reset cycle.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On the edge where req_valid & req_ready: latch req_write, req_addr and req_wdata; load counter with LATENCY-1.
  - Next state is WAIT if LATENCY > 1, otherwise RESP.
- WAIT:
  - req_ready = 0.
  - Counter decrements each cycle.
  - On the edge where the counter is 1, go to RESP.
- Entering RESP (a single edge):
  - Store: RAM[word] <= latched wdata; resp_rdata <= 0.
  - Load: resp_rdata <= RAM[word].
  - resp_valid <= 1.
  - Net effect: resp_valid is first high exactly LATENCY cycles after the accept edge.
- RESP:
  - resp_valid, resp_rdata and resp_err stay stable until resp_valid & resp_ready.
  - On the handshake edge: resp_valid <= 0, go to IDLE.
  - req_ready returns high in the following cycle. There is no same-cycle re-accept, so the minimum request-to-request spacing is LATENCY+1 cycles.
- Word index = req_addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias and wrap modulo 4*2**ADDR_WIDTH bytes.
- Inputs are ignored while req_ready = 0, and the latched request is never altered while busy.
- A load issued after a store to the same word returns the stored value, because stores commit before the store response is issued.
- Reset mid-transaction aborts it:
  - A store not yet in RESP is not committed.
  - resp_valid drops in the reset cycle.
  - The RAM is cleared regardless.
- Only LATENCY = 1 skips WAIT. Out-of-range LATENCY is not supported; simulation elaboration must flag it.

Optional Feature:
DMEM_ALIGN_CHECK_EN
- Defined: a request with req_addr[1:0] != 0 completes with normal timing, but with resp_err = 1 and resp_rdata = 0, and any store is suppressed (RAM unchanged).
- Undefined: req_addr[1:0] is ignored (the address is truncated to its word), resp_err is tied to 0, and no alignment logic is built.

Test Plan:
1. Basic store/load, LATENCY=2, resp_ready held 1: store addr 0x10 data 0xDEADBEEF, then load addr 0x10 -> resp_valid high 2 cycles after each accept; load resp_rdata = 0xDEADBEEF; store resp_rdata = 0; resp_err = 0.
2. Backpressure: load addr 0x10 with resp_ready = 0 for 5 cycles -> resp_valid and resp_rdata = 0xDEADBEEF held stable all 5 cycles; req_ready = 0 throughout; IDLE and req_ready = 1 one cycle after resp_ready rises.
3. LATENCY=1 build with back-to-back requests: req_valid held high with 4 stores to 0x0,0x4,0x8,0xC -> accepts spaced 2 cycles apart; readback returns all 4 values.
4. Wrap/alias, ADDR_WIDTH=8: store 0x12345678 to 0x400, load 0x000 -> rdata 0x12345678.
5. Reset mid-op: store 0xAAAA5555 to 0x20 with LATENCY=4, assert rst 2 cycles after accept -> resp_valid = 0; a load of 0x20 after reset returns 0.
6. DMEM_ALIGN_CHECK_EN defined: store 0xFFFFFFFF to 0x22 -> resp_err = 1; load 0x20 -> 0, resp_err = 0. Undefined: the same store lands in word 0x20; the load returns 0xFFFFFFFF.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bus between a CPU datapath (master) and the data-memory responder (slave).
// Both channels use valid/ready handshakes. Addresses are byte addresses.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM behind a valid/ready request/response bus, one access in flight, fixed LATENCY.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned accesses report resp_err and never touch the RAM.
module dmem_responder #(
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 2
) (
   input  logic             clk,
   input  logic             rst,
   dmem_responder_if.slave  bus,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam int         DEPTH      = 2 ** ADDR_WIDTH;
   localparam bit         SKIP_WAIT  = (LATENCY == 1);
   localparam logic [3:0] LOAD_COUNT = 4'(LATENCY - 1);

   generate
      if (LATENCY < 1 || LATENCY > 15) begin : g_badLatency
         $error("dmem_responder: LATENCY must be in 1..15");
      end
   endgenerate

   state_t                r_state;
   state_t                w_nextState;
   logic [3:0]            r_count;
   logic                  r_write;
   logic [ADDR_WIDTH-1:0] r_index;
   logic [31:0]           r_wdata;
   logic [31:0]           r_respRdata;
   logic [31:0]           r_mem [DEPTH];

   logic                  w_reqReady;
   logic                  w_respValid;
   logic                  w_accept;
   logic                  w_enterResp;
   logic                  w_curWrite;
   logic [ADDR_WIDTH-1:0] w_curIndex;
   logic [31:0]           w_curWdata;
   logic                  w_allowed;
   logic                  w_unused;

   // With LATENCY = 1 the RESP entry edge is also the accept edge, so the live request is used there.
   assign w_accept   = bus.req_valid && w_reqReady;
   assign w_curWrite = (r_state == IDLE) ? bus.req_write : r_write;
   assign w_curIndex = (r_state == IDLE) ? bus.req_addr[ADDR_WIDTH+1:2] : r_index;
   assign w_curWdata = (r_state == IDLE) ? bus.req_wdata : r_wdata;
   assign w_unused   = &{1'b0, bus.req_addr[31:ADDR_WIDTH+2], bus.req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
   logic r_misaligned;
   logic r_respErr;
   logic w_curMisaligned;

   assign w_curMisaligned = (r_state == IDLE) ? (bus.req_addr[1:0] != 2'b00) : r_misaligned;
   assign w_allowed       = !w_curMisaligned;
   assign bus.resp_err    = r_respErr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_misaligned <= 1'b0;
         r_respErr    <= 1'b0;
      end else begin
         if (w_accept) r_misaligned <= (bus.req_addr[1:0] != 2'b00);
         if (w_enterResp) r_respErr <= w_curMisaligned;
      end
   end
`else
   assign w_allowed    = 1'b1;
   assign bus.resp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = SKIP_WAIT ? RESP : WAIT;
         WAIT:    if (r_count == 4'd1) w_nextState = RESP;
         RESP:    if (bus.resp_ready) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      w_reqReady  = (r_state == IDLE);
      w_respValid = (r_state == RESP);
      busy        = (r_state != IDLE);
   end

   assign w_enterResp    = (w_nextState == RESP) && (r_state != RESP);
   assign bus.req_ready  = w_reqReady;
   assign bus.resp_valid = w_respValid;
   assign bus.resp_rdata = r_respRdata;

   // Stores commit on the RESP entry edge, so a following load always sees the new word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count     <= 4'd0;
         r_write     <= 1'b0;
         r_index     <= '0;
         r_wdata     <= 32'd0;
         r_respRdata <= 32'd0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
      end else begin
         if (w_accept) begin
            r_write <= bus.req_write;
            r_index <= bus.req_addr[ADDR_WIDTH+1:2];
            r_wdata <= bus.req_wdata;
            r_count <= LOAD_COUNT;
         end else if (r_state == WAIT) begin
            r_count <= r_count - 4'd1;
         end
         if (w_enterResp) begin
            if (w_curWrite) begin
               if (w_allowed) r_mem[w_curIndex] <= w_curWdata;
               r_respRdata <= 32'd0;
            end else begin
               r_respRdata <= w_allowed ? r_mem[w_curIndex] : 32'd0;
            end
         end
      end
   end

endmodule
